// File: rtl/spi_slave_rx_apb_if.sv
// rtl/spi_slave_rx_apb_if.sv - APB register-port interface used by spi_slave_rx_apb
//
// Signals: paddr[15:0], pwdata[31:0], prdata[31:0], psel, penable, pwrite, pready.
// Modports: master drives the request side, slave returns prdata/pready.
interface apb_if;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic        pready;

  modport master (output paddr, pwdata, psel, penable, pwrite,
                  input  prdata, pready);
  modport slave  (input  paddr, pwdata, psel, penable, pwrite,
                  output prdata, pready);
endinterface

// File: rtl/spi_slave_rx_apb.sv
// rtl/spi_slave_rx_apb.sv - APB-mapped SPI mode-0 slave receiver with byte FIFO
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   apb       apb_if.slave register port (CTRL 0x0, RXDATA 0x4, STATUS 0x8, CLEAR 0xC)
//   spi_sclk  SPI clock from master (asynchronous)
//   spi_mosi  serial data, MSB first
//   spi_cs    chip select, active low
//   irq       registered level interrupt: enable & (rx_not_empty | overrun | frame_err)
module spi_slave_rx_apb #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic  clk,
  input  logic  reset_n,
  apb_if.slave  apb,
  input  logic  spi_sclk,
  input  logic  spi_mosi,
  input  logic  spi_cs,
  output logic  irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // ---------------- input synchronizers and edge detect ----------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;  // cs idles high, so do not fake a frame start out of reset
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk;
  logic w_mosi;
  logic w_cs;
  logic w_sclk_rise;
  logic w_cs_rise;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;

  // ---------------- APB decode ----------------
  logic w_wr;
  logic w_rd;
  logic w_ctrl_wr;
  logic w_clr_wr;
  logic w_rx_rd;

  assign w_wr      = apb.psel & apb.penable & apb.pwrite;
  assign w_rd      = apb.psel & apb.penable & ~apb.pwrite;
  assign w_ctrl_wr = w_wr & (apb.paddr == 16'h0000);
  assign w_clr_wr  = w_wr & (apb.paddr == 16'h000C);
  assign w_rx_rd   = w_rd & (apb.paddr == 16'h0004);

  logic r_enable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_enable <= apb.pwdata[0];
    end
  end

  // ---------------- receive FSM ----------------
  logic [0:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_push;
  logic [7:0] r_push_data;
  logic       w_ferr_set;

  // Only a cs rise while still enabled can flag a short frame; a disable discards silently.
  assign w_ferr_set = (r_state == ST_SHIFT) & r_enable & w_cs_rise & (r_bit_cnt != 3'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_push      <= 1'b0;
      r_push_data <= 8'd0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_enable && !w_cs) begin
            r_state   <= ST_SHIFT;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
          end
        end
        ST_SHIFT: begin
          if (!r_enable) begin
            r_state <= ST_IDLE;
          end else if (w_cs_rise) begin
            r_state <= ST_IDLE;
          end else if (w_sclk_rise) begin
            r_shift   <= {r_shift[6:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_push      <= 1'b1;
              r_push_data <= {r_shift[6:0], w_mosi};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] w_count;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_ovr_set;

  assign w_count   = r_wptr - r_rptr;
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = w_rx_rd & ~w_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_push    = r_push & (~w_full | w_pop);
  assign w_ovr_set = r_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= r_push_data;
  end

  // ---------------- sticky flags and interrupt ----------------
  logic r_overrun;
  logic r_frame_err;
  logic r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      // set wins over a same-cycle clear
      r_overrun   <= w_ovr_set  | (r_overrun   & ~(w_clr_wr & apb.pwdata[2]));
      r_frame_err <= w_ferr_set | (r_frame_err & ~(w_clr_wr & apb.pwdata[3]));
      r_irq       <= r_enable & (~w_empty | r_overrun | r_frame_err);
    end
  end

  assign irq = r_irq;

  // ---------------- read mux ----------------
  logic [31:0] w_status;

  always_comb begin
    w_status             = '0;
    w_status[0]          = ~w_empty;
    w_status[1]          = w_full;
    w_status[2]          = r_overrun;
    w_status[3]          = r_frame_err;
    w_status[4]          = (r_state == ST_SHIFT);
    w_status[8 +: AW+1]  = w_count;
  end

  always_comb begin
    apb.prdata = '0;
    case (apb.paddr)
      16'h0000: apb.prdata = {31'd0, r_enable};
      16'h0004: apb.prdata = w_empty ? 32'd0 : {24'd0, r_mem[r_rptr[AW-1:0]]};
      16'h0008: apb.prdata = w_status;
      default:  apb.prdata = '0;
    endcase
  end

  assign apb.pready = 1'b1;

  logic w_unused;
  assign w_unused = ^{apb.pwdata[31:4], apb.pwdata[1]};

endmodule

// File: tb/tb_spi_slave_rx_apb.sv
// tb/tb_spi_slave_rx_apb.sv - self-checking bench for spi_slave_rx_apb
module tb_spi_slave_rx_apb;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_cs;
  logic irq;

  always #5 clk = ~clk;

  apb_if u_apb ();

  spi_slave_rx_apb #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .apb      (u_apb),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_cs   (spi_cs),
    .irq      (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: received bytes, sticky flags, enable and frame position.
  byte unsigned m_q[$];
  bit           m_en;
  bit           m_over;
  bit           m_ferr;
  bit           m_cs_low;
  int           m_bits;
  bit           settled;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = (m_q.size() != 0);
    s[1]    = (m_q.size() == DEPTH);
    s[2]    = m_over;
    s[3]    = m_ferr;
    s[4]    = m_en && m_cs_low;
    s[10:8] = 3'(m_q.size());
    return s;
  endfunction

  function automatic logic m_irq();
    return m_en && ((m_q.size() != 0) || m_over || m_ferr);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_push(input byte unsigned b);
    if (m_q.size() < DEPTH) m_q.push_back(b);
    else                    m_over = 1'b1;
  endtask

  task automatic cs_fall();
    settled = 1'b0;
    spi_cs  = 1'b0;
    m_cs_low = 1'b1;
    m_bits  = 0;
    tick(8);
    settled = 1'b1;
  endtask

  task automatic cs_rise();
    settled = 1'b0;
    spi_cs  = 1'b1;
    if (m_en && m_bits != 0) m_ferr = 1'b1;
    m_cs_low = 1'b0;
    tick(8);
    settled = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic [7:0] acc;
    settled = 1'b0;
    acc = 8'd0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      tick(6);
      spi_sclk = 1'b1;
      tick(6);
      spi_sclk = 1'b0;
      acc = {acc[6:0], b[7-i]};
      if (m_en && m_cs_low) begin
        m_bits = (m_bits + 1) % 8;
        if (m_bits == 0) model_push(acc);
      end
    end
    tick(4);
    settled = 1'b1;
  endtask

  task automatic apb_write(input logic [15:0] addr, input logic [31:0] data);
    bit prev;
    prev = settled;
    settled = 1'b0;
    u_apb.psel   = 1'b1;
    u_apb.pwrite = 1'b1;
    u_apb.paddr  = addr;
    u_apb.pwdata = data;
    tick(1);
    u_apb.penable = 1'b1;
    tick(1);
    u_apb.psel    = 1'b0;
    u_apb.penable = 1'b0;
    u_apb.pwrite  = 1'b0;
    u_apb.paddr   = 16'h0008;
    if (addr == 16'h0000) begin
      m_en = data[0];
      m_bits = 0;
    end
    if (addr == 16'h000C) begin
      if (data[2]) m_over = 1'b0;
      if (data[3]) m_ferr = 1'b0;
    end
    tick(3);
    settled = prev;
  endtask

  task automatic apb_read(input logic [15:0] addr, output logic [31:0] d);
    bit prev;
    prev = settled;
    settled = 1'b0;
    u_apb.psel   = 1'b1;
    u_apb.pwrite = 1'b0;
    u_apb.paddr  = addr;
    tick(1);
    u_apb.penable = 1'b1;
    @(negedge clk);
    d = u_apb.prdata;
    @(posedge clk);
    #1;
    u_apb.psel    = 1'b0;
    u_apb.penable = 1'b0;
    u_apb.paddr   = 16'h0008;
    if (addr == 16'h0004 && m_q.size() != 0) void'(m_q.pop_front());
    tick(3);
    settled = prev;
  endtask

  // Reads RXDATA, checks against the model head, and pins it to a literal too.
  task automatic read_rx(input string name, input logic [31:0] lit);
    logic [31:0] d;
    logic [31:0] exp;
    exp = (m_q.size() != 0) ? {24'd0, m_q[0]} : 32'd0;
    apb_read(16'h0004, d);
    check32({name, "_model"}, d, exp);
    check32({name, "_lit"}, d, lit);
  endtask

  task automatic read_reg(input string name, input logic [15:0] addr, input logic [31:0] lit);
    logic [31:0] d;
    apb_read(addr, d);
    check32(name, d, lit);
  endtask

  task automatic stimulus();
    logic [7:0] bb [4];
    logic [7:0] ov [5];

    tick(3);
    check32("reset_status", u_apb.prdata, 32'h0);
    check32("reset_irq", irq, 1'b0);
    reset_n = 1'b1;
    tick(3);
    settled = 1'b1;
    read_reg("reset_ctrl", 16'h0000, 32'h0);

    apb_write(16'h0000, 32'h1);
    read_reg("ctrl_en", 16'h0000, 32'h1);

    // single byte
    cs_fall();
    send_bits(8'hA5, 8);
    cs_rise();
    read_reg("a5_status", 16'h0008, 32'h101);
    check32("a5_irq", irq, 1'b1);
    read_rx("a5_data", 32'hA5);
    read_reg("a5_status_after", 16'h0008, 32'h0);

    // back-to-back bytes in one frame
    bb = '{8'h01, 8'h80, 8'hFF, 8'h3C};
    cs_fall();
    for (int i = 0; i < 4; i++) send_bits(bb[i], 8);
    cs_rise();
    read_reg("b2b_status", 16'h0008, 32'h403);
    for (int i = 0; i < 4; i++) begin
      read_rx("b2b_data", {24'd0, bb[i]});
      read_reg("b2b_count", 16'h0008, m_status());
    end

    // overrun
    ov = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    cs_fall();
    for (int i = 0; i < 5; i++) send_bits(ov[i], 8);
    cs_rise();
    read_reg("ovr_status", 16'h0008, 32'h407);
    for (int i = 0; i < 4; i++) read_rx("ovr_data", {24'd0, ov[i]});
    read_rx("ovr_empty", 32'h0);
    read_reg("ovr_flag", 16'h0008, 32'h004);
    read_reg("clear_rd", 16'h000C, 32'h0);
    apb_write(16'h000C, 32'h4);
    read_reg("ovr_cleared", 16'h0008, 32'h0);

    // frame error then good byte
    cs_fall();
    send_bits(8'hE0, 3);
    cs_rise();
    read_reg("ferr_status", 16'h0008, 32'h008);
    check32("ferr_irq", irq, 1'b1);
    cs_fall();
    send_bits(8'h5A, 8);
    cs_rise();
    read_rx("ferr_next", 32'h5A);
    apb_write(16'h000C, 32'h8);
    read_reg("ferr_cleared", 16'h0008, 32'h0);

    // disabled receive
    apb_write(16'h0000, 32'h0);
    cs_fall();
    send_bits(8'h77, 8);
    read_reg("dis_busy", 16'h0008, 32'h0);
    cs_rise();
    read_reg("dis_status", 16'h0008, 32'h0);
    check32("dis_irq", irq, 1'b0);

    // disable mid-byte
    apb_write(16'h0000, 32'h1);
    cs_fall();
    send_bits(8'h77, 3);
    read_reg("mid_busy", 16'h0008, 32'h010);
    apb_write(16'h0000, 32'h0);
    send_bits(8'hB8, 5);
    cs_rise();
    read_reg("mid_status", 16'h0008, 32'h0);
    check32("mid_irq", irq, 1'b0);

    // reset mid-byte with two entries
    apb_write(16'h0000, 32'h1);
    cs_fall();
    send_bits(8'h12, 8);
    send_bits(8'h34, 8);
    read_reg("rst_pre", 16'h0008, 32'h211);
    send_bits(8'hC0, 3);
    settled = 1'b0;
    reset_n = 1'b0;
    m_q.delete();
    m_en = 1'b0;
    m_over = 1'b0;
    m_ferr = 1'b0;
    m_bits = 0;
    tick(2);
    check32("rst_status", u_apb.prdata, 32'h0);
    check32("rst_irq", irq, 1'b0);
    spi_cs = 1'b1;
    m_cs_low = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    settled = 1'b1;
    read_rx("rst_rx", 32'h0);
    read_reg("rst_ctrl", 16'h0000, 32'h0);
    tick(4);
  endtask

  initial begin
    reset_n       = 1'b0;
    spi_sclk      = 1'b0;
    spi_mosi      = 1'b0;
    spi_cs        = 1'b1;
    u_apb.psel    = 1'b0;
    u_apb.penable = 1'b0;
    u_apb.pwrite  = 1'b0;
    u_apb.paddr   = 16'h0008;
    u_apb.pwdata  = 32'h0;
    m_en = 1'b0; m_over = 1'b0; m_ferr = 1'b0; m_cs_low = 1'b0; m_bits = 0;
    settled = 1'b0;
    fork
      begin
        forever begin
          @(negedge clk);
          if (settled && !u_apb.psel && u_apb.paddr == 16'h0008) begin
            check32("cyc_status", u_apb.prdata, m_status());
            check32("cyc_irq", irq, m_irq());
          end
        end
      end
      stimulus();
    join_any
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_apb.md
# spi_slave_rx_apb

APB-mapped SPI slave receiver for the peripheral subsystem: the receiving end of the SPI master's sclk/mosi/cs link. It samples the externally driven SPI pins in the `clk` domain, assembles MSB-first bytes, and buffers them in a small FIFO. Software drains the FIFO and reads status and error flags through the `apb_if.slave` register port. An `irq` output signals data or error conditions to the interrupt logic.

## Interface
- `FIFO_DEPTH`, default 4 — receive FIFO entries; power of 2, range 2..16.
- `SYNC_STAGES`, default 2 — synchronizer flops on each SPI input; minimum 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `apb`  slave modport  —  `apb_if.slave`: 16-bit `paddr`, 32-bit `pwdata`/`prdata`, plus `psel`, `penable`, `pwrite`, `pready`.
- `spi_sclk`  in  1  SPI clock from the master; asynchronous to `clk`.
- `spi_mosi`  in  1  serial data, MSB first.
- `spi_cs`  in  1  chip select, active low.
- `irq`  out  1  level interrupt: `enable & (rx_not_empty | overrun | frame_err)`.

## Operation
- **Input path**
  - Each SPI input passes through `SYNC_STAGES` flops.
  - One extra registered copy of the synchronized sclk and cs provides edge detection.
  - Bit sampling uses the synchronized mosi, taken on the cycle a synchronized sclk rising edge is detected (SPI mode 0).
- **Receive FSM states:** IDLE, SHIFT.
  - IDLE → SHIFT when `enable=1` and synchronized cs is low. Clear `bit_cnt` and `shift`.
  - SHIFT, on each sclk rise: `shift <= {shift[6:0], mosi}`, `bit_cnt++` (3-bit, wraps).
  - When `bit_cnt==7` on a rise, the byte is complete: push `{shift[6:0], mosi}` into the FIFO next cycle and stay in SHIFT for back-to-back bytes.
  - SHIFT → IDLE on synchronized cs rising. If `bit_cnt!=0`, discard the partial byte and set `frame_err`.
  - SHIFT → IDLE when `enable` is written 0. Discard the partial byte; no flag is set.
- **FIFO**
  - `FIFO_DEPTH` entries, wrap-around read/write pointers with one extra bit for full/empty.
  - Push while full: drop the byte and set sticky `overrun`.
  - Push and pop in the same cycle while full: both occur, no overrun.
- **Registers** (`pready` tied to 1; writes take effect on `psel & penable & pwrite`):
  - `0x0000` CTRL, RW: bit0 `enable`, reset 0.
  - `0x0004` RXDATA, RO: `prdata[7:0]` = FIFO head; 0 when empty. A read access (`psel & penable & !pwrite`) pops one entry; popping when empty has no effect.
  - `0x0008` STATUS, RO:
    - bit0 `rx_not_empty`
    - bit1 `full`
    - bit2 `overrun`
    - bit3 `frame_err`
    - bit4 `busy` (FSM in SHIFT)
    - bits[8+clog2(FIFO_DEPTH):8] `count`
  - `0x000C` CLEAR, WO: write 1 to bit2 clears `overrun`; write 1 to bit3 clears `frame_err`. Reads return 0.
  - Other addresses: reads return 0, writes are ignored.
- A flag set in the same cycle as a CLEAR write of that flag stays set; set wins.
- `prdata` is combinational from `paddr`.

## Timing
- **Reset:** FSM = IDLE, FIFO empty, `enable=0`, all flags 0, `irq=0`, `prdata=0`, synchronizers 0, cs synchronizer 1.
- **Input constraint:** sclk high and low phases each ≥ `SYNC_STAGES+2` clk periods. cs falling must come ≥ `SYNC_STAGES+2` clk periods before the first sclk rise.
- **Latency:**
  - Pin sclk rise to bit sampled: `SYNC_STAGES+1` clk cycles.
  - 8th sclk rise to `rx_not_empty=1`: `SYNC_STAGES+2` cycles.
  - `irq` follows status with 1 additional cycle (registered).
- **Pop timing:** the FIFO head updates the cycle after the RXDATA access phase, and `count` decrements that same cycle.
- **Reset mid-byte:** everything returns to reset values immediately; no partial data survives.

## Test plan
- Enable; master sends 0xA5 with cs low → STATUS=0x101 after completion; RXDATA reads 0xA5; STATUS then 0x000.
- Back-to-back 0x01, 0x80, 0xFF, 0x3C in one cs frame → four RXDATA reads return them in order; `count` steps 4→0.
- Send 5 bytes with no reads (DEPTH=4) → STATUS bits0–2 set; RXDATA returns the first four bytes; the 5th is lost; write 0x4 to CLEAR → `overrun=0`.
- Raise cs after 3 bits → `frame_err=1`, FIFO empty, `irq=1`; next full byte 0x5A is received correctly.
- `enable=0` while a master sends 0x77 → FIFO stays empty, `busy=0`, `irq=0`. Disable mid-byte → partial byte discarded, no flags.
- Assert `reset_n` low mid-byte with FIFO holding 2 entries → all status and `irq` 0; RXDATA reads 0.
